// File: rtl/latch_bank.sv
// latch_bank: per-bit set/clear latches with direct load and a round-robin
// read-and-clear handshake.
module latch_bank #(
  parameter int W = 4,
  parameter int N = 2,
  parameter int CLR_PRI = 1,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N*W-1:0]  i_set,
  input  logic [N*W-1:0]  i_clear,
  input  logic            i_ld_en,
  input  logic [CW-1:0]   i_ld_ch,
  input  logic [W-1:0]    i_ld_data,
  input  logic            i_rd_req,
  output logic            o_rd_ack,
  output logic [CW-1:0]   o_rd_ch,
  output logic [W-1:0]    o_rd_data,
  output logic [N*W-1:0]  o_out,
  output logic [N-1:0]    o_any,
  output logic            o_irq
);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT} st_t;
  st_t st_q, st_d;
  logic [N*W-1:0] out_q, out_d;
  logic [CW-1:0] sel_q, sel_d, last_q, last_d, pick;
  logic [W-1:0] data_q, data_d, cur;
  for (genvar g = 0; g < N; g++) begin : g_any
    assign o_any[g] = |out_q[g*W +: W];
  end
  assign o_out     = out_q;
  assign o_irq     = |o_any;
  assign cur       = out_q[int'(sel_q)*W +: W];
  assign o_rd_ack  = (st_q == GRANT);
  assign o_rd_ch   = sel_q;
  assign o_rd_data = o_rd_ack ? cur : data_q;
  // Scan downward so the channel nearest after last-served wins.
  always_comb begin
    pick = last_q;
    for (int i = N; i >= 1; i--)
      if (o_any[(int'(last_q) + i) % N]) pick = CW'((int'(last_q) + i) % N);
  end
  // Load beats read-clear, read-clear beats set/clear; set bits survive a read.
  always_comb begin
    out_d = out_q;
    for (int c = 0; c < N; c++) begin
      out_d[c*W +: W] = (CLR_PRI != 0)
        ? (out_q[c*W +: W] | i_set[c*W +: W]) & ~i_clear[c*W +: W]
        : (out_q[c*W +: W] & ~i_clear[c*W +: W]) | i_set[c*W +: W];
      if (st_q == GRANT && int'(sel_q) == c) out_d[c*W +: W] = i_set[c*W +: W];
      if (i_ld_en && int'(i_ld_ch) == c) out_d[c*W +: W] = i_ld_data;
    end
  end
  always_comb begin
    st_d   = st_q;
    sel_d  = sel_q;
    last_d = last_q;
    data_d = data_q;
    case (st_q)
      IDLE: if (i_rd_req && o_irq) begin
        st_d  = GRANT;
        sel_d = pick;
      end
      GRANT: begin
        st_d   = WAIT;
        last_d = sel_q;
        data_d = cur;
      end
      WAIT:    st_d = i_rd_req ? WAIT : IDLE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      st_q   <= IDLE;
      out_q  <= '0;
      sel_q  <= '0;
      last_q <= CW'(N - 1);
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      out_q  <= out_d;
      sel_q  <= sel_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end
endmodule

// File: doc/latch_bank.md
LATCH_BANK -- requirements
Module: latch_bank

Interface
REQ-001 W, default 4: bits per channel.
REQ-002 N, default 2: channel count, N>=1; CW = max(1, clog2(N)).
REQ-003 CLR_PRI, default 1: 1 = clear dominates set on the same bit in the same cycle; 0 = set dominates.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-low.
REQ-006 i_set  in  N*W  per-bit set strobes; channel c occupies bits [c*W +: W].
REQ-007 i_clear  in  N*W  per-bit clear strobes, same layout as i_set.
REQ-008 i_ld_en  in  1  direct-load enable.
REQ-009 i_ld_ch  in  CW  channel to load.
REQ-010 i_ld_data  in  W  value to load.
REQ-011 i_rd_req  in  1  read-and-clear request, 4-phase handshake.
REQ-012 o_rd_ack  out  1  one-cycle acknowledge pulse.
REQ-013 o_rd_ch  out  CW  channel served by the current acknowledge.
REQ-014 o_rd_data  out  W  snapshot of the served channel.
REQ-015 o_out  out  N*W  latch state, registered.
REQ-016 o_any  out  N  per-channel OR of o_out; combinational from o_out.
REQ-017 o_irq  out  1  OR of o_any.

Function
REQ-018 Per bit, without load or read-clear: next = CLR_PRI ? (q|set)&~clr : (q&~clr)|set.
REQ-019 i_ld_en=1 replaces channel i_ld_ch with i_ld_data next edge; overrides set/clear on that channel; other channels unaffected.
REQ-020 i_ld_ch >= N with i_ld_en=1: no effect.
REQ-021 FSM states: IDLE, GRANT, WAIT.
REQ-022 IDLE: if i_rd_req=1 and o_irq=1, select a channel and go to GRANT; otherwise remain in IDLE (request stays pending).
REQ-023 Selection: round-robin; first channel with o_any=1, searching upward from last-served+1 with wrap at N-1 -> 0.
REQ-024 GRANT (one cycle): o_rd_ack=1; o_rd_ch = selected channel; o_rd_data = that channel's o_out value in this cycle.
REQ-025 GRANT edge: served channel's bits are cleared, except bits whose i_set is 1 in this cycle, which end at 1 (no event lost, whatever CLR_PRI).
REQ-026 GRANT edge: a same-cycle i_ld_en to the served channel takes priority over the read-clear; last-served pointer updates; next state WAIT.
REQ-027 WAIT: o_rd_ack=0; go to IDLE when i_rd_req=0.
REQ-028 Latency: i_rd_req and o_irq both sampled high at edge k -> o_rd_ack high for exactly the cycle after edge k; at most one acknowledge per request assertion.
REQ-029 i_rd_req dropping during GRANT does not cancel the acknowledge or the clear.
REQ-030 o_rd_data and o_rd_ch hold their last values outside GRANT.
REQ-031 N=1: pointer logic degenerates; o_rd_ch is always 0.

Reset
REQ-032 i_rst=0 immediately forces o_out=0, o_rd_ack=0, o_rd_ch=0, o_rd_data=0, FSM=IDLE, last-served=N-1 (channel 0 served first).
REQ-033 Reset asserted mid-handshake aborts it; after release, a still-high i_rd_req is treated as a new request.
REQ-034 Release is synchronous to the first rising edge after i_rst goes high; no state change on that edge from pre-release inputs.

Verification (W=4, N=2, CLR_PRI=1 unless stated)
REQ-035 Bench covers: i_set=0x08, then 0x0C, then 0x06 over 3 cycles -> o_out=0x08, 0x0C, 0x0E; i_clear=0x04 -> o_out=0x0A.
REQ-036 Bench covers: o_out=0, same-cycle i_set=0x01 and i_clear=0x01 -> o_out=0x00; with CLR_PRI=0 -> o_out=0x01.
REQ-037 Bench covers: o_out=0x53, i_rd_req held high -> ack with ch0, data 3, then o_out=0x50; after drop and re-raise of i_rd_req -> ack with ch1, data 5, then o_out=0x00.
REQ-038 Bench covers: during GRANT for ch0 (value 0x3), i_set=0x04 -> o_rd_data=3, then o_out[3:0]=0x4.
REQ-039 Bench covers: i_rd_req high with o_out=0 for 5 cycles, then i_set=0x20 -> ack one cycle after o_irq rises, with ch1, data 2.
REQ-040 Bench covers: i_rst=0 in GRANT cycle -> o_rd_ack and o_out are 0 immediately; after release with i_rd_req high and o_irq=0, no ack.
